// File: rtl/uart_tx_pkg.sv
// uart_tx shared definitions: FSM state encoding, parity control bit
// positions (common with the receiver) and the default bit period.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        UART_TX_IDLE,
        UART_TX_START,
        UART_TX_DATA,
        UART_TX_PARITY,
        UART_TX_STOP
    } uart_tx_state_e;

    localparam int UART_PAR_EN  = 1;
    localparam int UART_PAR_ODD = 0;

    localparam int unsigned UART_CLKS_PER_BIT = 8;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] parity,
    input  logic [7:0] txdata,
    input  logic       txstart,
    output logic       ready,
    output logic       tx,
    output logic       txdone
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    uart_tx_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     sh_q, sh_d;
    logic [1:0]     par_q, par_d;
    logic           acc_q, acc_d;
    logic           tx_q, tx_d;
    logic           bit_end;
    logic           last_stop;

`ifdef UART_TX_TWO_STOP_EN
    logic stop2_q, stop2_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stop2_q <= 1'b0;
        else     stop2_q <= stop2_d;
    end

    assign last_stop = stop2_q;
`else
    assign last_stop = 1'b1;
`endif

    assign bit_end = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UART_TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= '0;
            acc_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            acc_q   <= acc_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the line value for the state being entered, so tx stays a flop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        acc_d   = acc_q;
        tx_d    = tx_q;
`ifdef UART_TX_TWO_STOP_EN
        stop2_d = stop2_q;
`endif
        if (state_q != UART_TX_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end
        unique case (state_q)
            UART_TX_IDLE: begin
                tx_d = 1'b1;
                if (txstart) begin
                    state_d = UART_TX_START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh_d    = txdata;
                    par_d   = parity;
                    acc_d   = 1'b0;
                    tx_d    = 1'b0;
                end
            end
            UART_TX_START: begin
                if (bit_end) begin
                    state_d = UART_TX_DATA;
                    tx_d    = sh_q[0];
                end
            end
            UART_TX_DATA: begin
                if (bit_end) begin
                    sh_d  = {1'b0, sh_q[7:1]};
                    acc_d = acc_q ^ sh_q[0];
                    bit_d = bit_q + 3'd1;
                    if (bit_q != 3'd7) begin
                        tx_d = sh_q[1];
                    end else if (par_q[UART_PAR_EN]) begin
                        state_d = UART_TX_PARITY;
                        tx_d    = acc_q ^ sh_q[0] ^ par_q[UART_PAR_ODD];
                    end else begin
                        state_d = UART_TX_STOP;
                        tx_d    = 1'b1;
                    end
                end
            end
            UART_TX_PARITY: begin
                if (bit_end) begin
                    state_d = UART_TX_STOP;
                    tx_d    = 1'b1;
                end
            end
            UART_TX_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    stop2_d = ~stop2_q;
`endif
                    if (last_stop) state_d = UART_TX_IDLE;
                end
            end
            default: begin
                state_d = UART_TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign ready  = (state_q == UART_TX_IDLE);
    assign tx     = tx_q;
    assign txdone = (state_q == UART_TX_STOP) && bit_end && last_stop;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-cycle line scoreboard plus a
// mid-bit byte decoder checked against the bytes queued at request time.
module tb_uart_tx;

    localparam int CPB = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] parity;
    logic [7:0] txdata;
    logic       txstart;
    logic       ready;
    logic       tx;
    logic       txdone;

    int checks = 0;
    int errors = 0;
    int frames_sent = 0;
    int done_seen = 0;

    logic bit_q[$];
    logic [8:0] byte_q[$];

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .parity  (parity),
        .txdata  (txdata),
        .txstart (txstart),
        .ready   (ready),
        .tx      (tx),
        .txdone  (txdone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected per-cycle line and the expected {parity, byte}
    task automatic push_frame(input logic [7:0] d, input logic [1:0] p,
                              output int n);
        logic pb;
        pb = ^d ^ p[0];
        n = 0;
        for (int k = 0; k < CPB; k++) begin bit_q.push_back(1'b0); n++; end
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < CPB; k++) begin bit_q.push_back(d[b]); n++; end
        if (p[1])
            for (int k = 0; k < CPB; k++) begin bit_q.push_back(pb); n++; end
        for (int k = 0; k < CPB * NSTOP; k++) begin bit_q.push_back(1'b1); n++; end
        byte_q.push_back({p[1] ? pb : 1'b0, d});
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [1:0] p,
                             input bit hold, input bit mutate);
        int n;
        logic [8:0] got;
        logic [8:0] exp;
        logic e;
        push_frame(d, p, n);
        frames_sent++;
        txdata  = d;
        parity  = p;
        txstart = 1'b1;
        chk("ready_before_accept", ready, 1);
        tick();
        if (!hold) txstart = 1'b0;
        got = '0;
        for (int c = 1; c <= n; c++) begin
            e = bit_q.pop_front();
            chk("tx_cycle", tx, e);
            chk("txdone_cycle", txdone, (c == n));
            chk("ready_busy", ready, 0);
            if (txdone) done_seen++;
            if (c % CPB == CPB / 2) begin
                int bi;
                bi = c / CPB;
                if (bi >= 1 && bi <= 8) got[bi-1] = tx;
                if (bi == 9 && p[1]) got[8] = tx;
            end
            if (mutate) begin
                txdata = 8'($urandom);
                parity = 2'($urandom);
                if (!hold) txstart = 1'($urandom);
            end
            if (c == n && !hold) txstart = 1'b0;
            tick();
        end
        exp = byte_q.pop_front();
        chk("decoded_byte", got, exp);
        chk("gap_tx_idle", tx, 1);
        chk("gap_ready", ready, 1);
        chk("gap_txdone", txdone, 0);
    endtask

    initial begin
        logic [7:0] pat[4];
        int n;
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h3C; pat[3] = 8'hA5;
        rst = 1'b1;
        parity = 2'b00;
        txdata = 8'h00;
        txstart = 1'b0;
        #12;
        chk("reset_tx", tx, 1);
        chk("reset_ready", ready, 1);
        chk("reset_txdone", txdone, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_tx", tx, 1);

        run_frame(8'h55, 2'b00, 1'b0, 1'b0);
        run_frame(8'hA5, 2'b10, 1'b0, 1'b0);
        run_frame(8'hA5, 2'b11, 1'b0, 1'b0);

        for (int pi = 0; pi < 4; pi++)
            for (int di = 0; di < 4; di++)
                run_frame(pat[di], 2'(pi), 1'b0, 1'b0);

        // txstart held: one idle cycle between frames
        run_frame(8'h3C, 2'b10, 1'b1, 1'b0);
        run_frame(8'hC3, 2'b00, 1'b1, 1'b0);
        run_frame(8'h81, 2'b11, 1'b0, 1'b0);

        // mid-frame txdata/parity/txstart churn is ignored
        run_frame(8'h96, 2'b11, 1'b0, 1'b1);
        run_frame(8'h4B, 2'b00, 1'b0, 1'b1);
        run_frame(8'hE7, 2'b10, 1'b0, 1'b1);

        chk("txdone_count", done_seen, frames_sent);

        // reset at cycle 40: cycles 33..40 carry data bit 3
        push_frame(8'h08, 2'b10, n);
        txdata = 8'h08;
        parity = 2'b10;
        txstart = 1'b1;
        tick();
        txstart = 1'b0;
        repeat (39) tick();
        chk("pre_reset_bit3", tx, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", tx, 1);
        chk("async_rst_ready", ready, 1);
        chk("async_rst_txdone", txdone, 0);
        bit_q.delete();
        byte_q.delete();
        tick();
        rst = 1'b0;
        tick();
        run_frame(8'h5A, 2'b01, 1'b0, 1'b0);
        run_frame(8'h55, 2'b00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
